// File: rtl/bsearch_pkg.sv
// rtl/bsearch_pkg.sv - shared types for the binary-search engine
package bsearch_pkg;

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} bs_state_t;

  typedef enum logic {EXACT = 1'b0, LOWER_BOUND = 1'b1} bs_mode_t;

endpackage

// File: rtl/bsearch_if.sv
// rtl/bsearch_if.sv - request/result and memory read-port bundle for bsearch_engine
interface bsearch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int PW     = $clog2(ADDR_W + 2)
);
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] target;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] addr;
  logic [PW-1:0]     probes;

  // engine side
  modport slave (
    input  start, mode, target, mem_rdata,
    output mem_addr, mem_rd, busy, done, found, addr, probes
  );

  // board / memory side
  modport master (
    output start, mode, target, mem_rdata,
    input  mem_addr, mem_rd, busy, done, found, addr, probes
  );
endinterface

// File: rtl/bsearch_engine.sv
// rtl/bsearch_engine.sv - binary search (exact / lower bound) over a sorted synchronous-read memory
module bsearch_engine
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  bsearch_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = $clog2(ADDR_W + 2);
  localparam int LW    = ADDR_W + 1;
  localparam int CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q;
  logic              arm_q;
  bs_mode_t          mode_q;
  logic [DATA_W-1:0] target_q;
  logic [LW-1:0]     lo_q, hi_q;
  logic [CW-1:0]     wait_q;
  logic              busy_q, done_q, found_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PW-1:0]     probes_q;

  logic [LW-1:0]     mid;
  logic [LW-1:0]     lo_d, hi_d;
  logic              fin_d, found_d;
  logic [ADDR_W-1:0] addr_d;

  // lo/hi are one bit wider than an address so hi=DEPTH and lo=mid+1 never wrap;
  // the sum gets one more bit before halving
  assign mid = LW'(((LW + 1)'(lo_q) + (LW + 1)'(hi_q)) >> 1);

  assign bus.mem_addr = mid[ADDR_W-1:0];
  assign bus.mem_rd   = (state_q == S_READ) && (wait_q == CW'(0));
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.found    = found_q;
  assign bus.addr     = addr_q;
  assign bus.probes   = probes_q;

  // narrow the search interval from one probe result and decide whether it is finished
  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    fin_d   = 1'b0;
    found_d = 1'b0;
    addr_d  = '0;
    if (mode_q == EXACT) begin
      if (bus.mem_rdata == target_q) begin
        fin_d   = 1'b1;
        found_d = 1'b1;
        addr_d  = mid[ADDR_W-1:0];
      end else if (bus.mem_rdata < target_q) begin
        lo_d = mid + LW'(1);
      end else if (mid == '0) begin
        fin_d = 1'b1;
      end else begin
        hi_d = mid - LW'(1);
      end
      if (!fin_d && (lo_d > hi_d)) fin_d = 1'b1;
    end else begin
      if (bus.mem_rdata < target_q) lo_d = mid + LW'(1);
      else                          hi_d = mid;
      if (lo_d == hi_d) begin
        fin_d   = 1'b1;
        found_d = (lo_d < LW'(DEPTH));
        addr_d  = found_d ? lo_d[ADDR_W-1:0] : '0;
      end
    end
  end

  // control FSM, request latching and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      arm_q    <= 1'b0;
      mode_q   <= EXACT;
      target_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      addr_q   <= '0;
      probes_q <= '0;
    end else begin
      // armed only after start has been seen low, so a held-high start never relaunches
      arm_q <= ~bus.start;
      case (state_q)
        S_IDLE: begin
          if (bus.start && arm_q) begin
            mode_q   <= bs_mode_t'(bus.mode);
            target_q <= bus.target;
            lo_q     <= '0;
            hi_q     <= bus.mode ? LW'(DEPTH) : LW'(DEPTH - 1);
            wait_q   <= '0;
            probes_q <= '0;
            found_q  <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          if (wait_q == CW'(RD_LAT - 1)) begin
            wait_q  <= '0;
            state_q <= S_CMP;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        S_CMP: begin
          if (probes_q != '1) probes_q <= probes_q + PW'(1);
          lo_q <= lo_d;
          hi_q <= hi_d;
          if (fin_d) begin
            found_q <= found_d;
            addr_q  <= addr_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_READ;
          end
        end
        default: begin
          if (!bus.start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_engine.sv
// tb/tb_bsearch_engine.sv - self-checking bench for bsearch_engine
module tb_bsearch_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  bsearch_if #(.DATA_W(8),  .ADDR_W(5)) ifa ();
  bsearch_if #(.DATA_W(16), .ADDR_W(8)) ifb ();

  bsearch_engine #(.DATA_W(8),  .ADDR_W(5), .RD_LAT(1)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
  bsearch_engine #(.DATA_W(16), .ADDR_W(8), .RD_LAT(3)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

  logic [7:0]  mem_a [32];
  logic [15:0] mem_b [256];
  logic [7:0]  ra;
  logic [15:0] rb [3];

  // synchronous-read memories with latency 1 (A) and 3 (B)
  always @(posedge clk) begin
    ra    <= mem_a[ifa.mem_addr];
    rb[0] <= mem_b[ifb.mem_addr];
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end
  assign ifa.mem_rdata = ra;
  assign ifb.mem_rdata = rb[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: linear scan of the sorted contents
  function automatic void model(input bit sel_b, input bit m, input int t, output bit f, output int a);
    int n;
    int v;
    n = sel_b ? 256 : 32;
    f = 1'b0;
    a = 0;
    for (int i = 0; i < n; i++) begin
      v = sel_b ? int'(mem_b[i]) : int'(mem_a[i]);
      if (!f && ((m == 1'b0 && v == t) || (m == 1'b1 && v >= t))) begin
        f = 1'b1;
        a = i;
      end
    end
  endfunction

  bit exp_v_a = 0, exp_f_a = 0;
  int exp_ad_a = 0;
  bit exp_v_b = 0, exp_f_b = 0;
  int exp_ad_b = 0;

  int rd_a = 0, busy_a = 0, rd_b = 0, busy_b = 0;
  bit done_pa = 0, done_pb = 0;

  // per-cycle comparison of both engines against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_a = 0; busy_a = 0; done_pa = 0;
      rd_b = 0; busy_b = 0; done_pb = 0;
    end else begin
      if (ifa.mem_rd) rd_a++;
      if (ifa.busy)   busy_a++;
      if (ifb.mem_rd) rd_b++;
      if (ifb.busy)   busy_b++;
      if (ifa.done && exp_v_a) begin
        chk("a_found", ifa.found, exp_f_a);
        chk("a_addr", ifa.addr, exp_f_a ? exp_ad_a : 0);
        if (!done_pa) begin
          chk("a_rd_per_probe", rd_a, ifa.probes);
          chk("a_busy_cycles", busy_a, 2 * ifa.probes);
          chk("a_probe_range", ifa.probes inside {[1:6]}, 1);
          rd_a = 0; busy_a = 0;
        end
      end
      if (ifb.done && exp_v_b) begin
        chk("b_found", ifb.found, exp_f_b);
        chk("b_addr", ifb.addr, exp_f_b ? exp_ad_b : 0);
        if (!done_pb) begin
          chk("b_rd_per_probe", rd_b, ifb.probes);
          chk("b_busy_cycles", busy_b, 4 * ifb.probes);
          chk("b_probe_range", ifb.probes inside {[1:9]}, 1);
          rd_b = 0; busy_b = 0;
        end
      end
      done_pa = ifa.done;
      done_pb = ifb.done;
    end
  end

  task automatic search_a(input bit m, input int t, input int low,
                          output logic f, output logic [4:0] a, output logic [2:0] p);
    int n;
    bit ef;
    int ea;
    ifa.start = 1'b0;
    repeat (low) begin @(posedge clk); #1; end
    model(1'b0, m, t, ef, ea);
    exp_f_a = ef; exp_ad_a = ea; exp_v_a = 1'b1;
    ifa.mode = m; ifa.target = t[7:0]; ifa.start = 1'b1;
    n = 0;
    while (!ifa.done && n < 300) begin @(posedge clk); #1; n++; end
    chk("a_no_timeout", n < 300, 1);
    f = ifa.found; a = ifa.addr; p = ifa.probes;
  endtask

  task automatic search_b(input bit m, input int t);
    int n;
    bit ef;
    int ea;
    ifb.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    model(1'b1, m, t, ef, ea);
    exp_f_b = ef; exp_ad_b = ea; exp_v_b = 1'b1;
    ifb.mode = m; ifb.target = t[15:0]; ifb.start = 1'b1;
    n = 0;
    while (!ifb.done && n < 1000) begin @(posedge clk); #1; n++; end
    chk("b_no_timeout", n < 1000, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic f;
    logic [4:0] a;
    logic [2:0] p;
    int n, rd;
    int v;

    for (int i = 0; i < 32; i++) mem_a[i] = 8'(2 * i + 1);
    v = 0;
    for (int i = 0; i < 256; i++) begin
      v += $urandom_range(1, 200);
      mem_b[i] = 16'(v);
    end

    rst_n = 1'b0;
    ifa.start = 0; ifa.mode = 0; ifa.target = 0;
    ifb.start = 0; ifb.mode = 0; ifb.target = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_found", ifa.found, 0);
    chk("rst_addr", ifa.addr, 0);
    chk("rst_probes", ifa.probes, 0);
    chk("rst_mem_rd", ifa.mem_rd, 0);
    rst_n = 1'b1;

    // directed searches with hand-computed results
    search_a(1'b0, 7, 2, f, a, p);
    chk("ex7_found", f, 1); chk("ex7_addr", a, 3); chk("ex7_probes", p, 3);
    search_a(1'b0, 8, 2, f, a, p);
    chk("ex8_found", f, 0); chk("ex8_addr", a, 0); chk("ex8_probes", p, 5);
    search_a(1'b0, 0, 2, f, a, p);
    chk("ex0_found", f, 0); chk("ex0_addr", a, 0); chk("ex0_probes", p, 5);
    search_a(1'b1, 0, 2, f, a, p);
    chk("lb0_found", f, 1); chk("lb0_addr", a, 0); chk("lb0_probes", p, 6);
    search_a(1'b1, 200, 2, f, a, p);
    chk("lb200_found", f, 0); chk("lb200_addr", a, 0);
    search_a(1'b1, 63, 2, f, a, p);
    chk("lb63_found", f, 1); chk("lb63_addr", a, 31);
    search_a(1'b1, 8, 2, f, a, p);
    chk("lb8_found", f, 1); chk("lb8_addr", a, 4); chk("lb8_probes", p, 5);

    // start held high after done: no relaunch, outputs held
    rd = 0;
    repeat (10) begin @(posedge clk); #1; if (ifa.mem_rd) rd++; end
    chk("hold_done", ifa.done, 1);
    chk("hold_busy", ifa.busy, 0);
    chk("hold_no_rd", rd, 0);
    chk("hold_addr", ifa.addr, 4);

    // single-cycle low of start in DONE relaunches with the new target
    search_a(1'b0, 41, 1, f, a, p);
    chk("relaunch_found", f, 1); chk("relaunch_addr", a, 20);
    search_a(1'b0, 63, 2, f, a, p);
    chk("ex63_addr", a, 31);

    // reset in the READ of probe 2, start still high at release
    ifa.start = 1'b0;
    exp_v_a = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ifa.mode = 1'b0; ifa.target = 8'd1; ifa.start = 1'b1;
    rd = 0; n = 0;
    while (rd < 2 && n < 100) begin @(posedge clk); #1; n++; if (ifa.mem_rd) rd++; end
    chk("rst2_reached_probe2", rd, 2);
    rst_n = 1'b0;
    #1;
    chk("rst2_busy", ifa.busy, 0);
    chk("rst2_done", ifa.done, 0);
    chk("rst2_found", ifa.found, 0);
    chk("rst2_addr", ifa.addr, 0);
    chk("rst2_probes", ifa.probes, 0);
    chk("rst2_mem_rd", ifa.mem_rd, 0);
    chk("rst2_mem_addr", ifa.mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd = 0; n = 0;
    repeat (6) begin @(posedge clk); #1; if (ifa.mem_rd) rd++; if (ifa.busy) n++; end
    chk("rel_no_rd", rd, 0);
    chk("rel_no_busy", n, 0);
    search_a(1'b0, 1, 2, f, a, p);
    chk("after_rst_addr", a, 0); chk("after_rst_found", f, 1);

    // wide engine, latency 3, random sorted contents
    search_b(1'b0, 0);
    search_b(1'b1, 0);
    search_b(1'b0, int'(mem_b[0]));
    search_b(1'b0, int'(mem_b[255]));
    search_b(1'b1, 65535);
    search_b(1'b1, int'(mem_b[255]));
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) search_b(k[0], int'(mem_b[$urandom_range(0, 255)]));
      else if (k % 3 == 1) search_b(k[0], int'(mem_b[$urandom_range(0, 255)]) + 1);
      else search_b(k[0], int'($urandom_range(0, 55000)));
    end
    ifb.start = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
